stall_controller: RTL and testbench
===================================

# stall_controller

Pipeline stall/flush controller that drives the hold and bubble inputs of the IF/ID and ID/EX pipeline registers. It detects load-use hazards between ID and EX, freezes the whole pipeline while a data-memory access waits for acknowledge, and converts taken branches into flushes. It is the producer of the `Data_Stall` signal consumed by the ID/EX register. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in MEM_WAIT before `Mem_Err_o` is raised. A value of 0 disables the timeout.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk_i` input 1: the single clock. All state updates on its rising edge.
- `rst_i` input 1: reset. Synchronous, active-low.
- `IDEX_MemRead_i` input 1: the instruction in EX is a load.
- `IDEX_Rd_i` input 5: destination register of the instruction in EX.
- `IFID_Rs1_i`, `IFID_Rs2_i` input 5 each: source registers of the instruction in ID.
- `IFID_UseRs1_i`, `IFID_UseRs2_i` input 1 each: the instruction in ID actually reads the corresponding source register.
- `Mem_Req_i` input 1: the MEM stage is issuing a data-memory access this cycle.
- `Mem_Ack_i` input 1: data memory completes the access this cycle.
- `Branch_Taken_i` input 1: a branch resolved taken in EX.
- `PC_Write_o` output 1: PC update enable.
- `IFID_Write_o` output 1: IF/ID load enable.
- `Data_Stall_o` output 1: holds ID/EX (and later stages) when high.
- `Bubble_o` output 1: forces ID/EX control fields to zero (NOP).
- `Flush_o` output 1: clears IF/ID and ID/EX.
- `Mem_Err_o` output 1: sticky memory-timeout flag.
- `Stall_Cycles_o` output CNT_W: saturating count of stall and bubble cycles.

## Operation
- FSM states are RUN and MEM_WAIT.
- **RUN → MEM_WAIT:** taken when `Mem_Req_i & ~Mem_Ack_i`.
- **MEM_WAIT → RUN:** taken on the cycle after `Mem_Ack_i`=1.
- **Memory stall:**
  - `Data_Stall_o` = (RUN & `Mem_Req_i` & ~`Mem_Ack_i`) | (MEM_WAIT & ~`Mem_Ack_i`).
  - While `Data_Stall_o` is high: `PC_Write_o`=0, `IFID_Write_o`=0, `Bubble_o`=0, `Flush_o`=0.
- **Load-use hazard (`lu`):** `IDEX_MemRead_i` & `IDEX_Rd_i`≠0 & ((`IFID_UseRs1_i` & Rs1==Rd) | (`IFID_UseRs2_i` & Rs2==Rd)).
  - Response: `PC_Write_o`=0, `IFID_Write_o`=0, `Bubble_o`=1 for exactly that cycle.
  - The inserted bubble clears `IDEX_MemRead_i`, so the condition lapses without extra state.
- **Flush:** `Branch_Taken_i` in RUN with no memory stall gives `Flush_o`=1 and `PC_Write_o`=1, with no bubble.
  - If `Branch_Taken_i` arrives while `Data_Stall_o`=1, it is latched in `flush_pend`.
  - `flush_pend` is applied as `Flush_o`=1 on the first non-stalled cycle, then cleared.
- **Priority:** memory stall > flush (live or pending) > load-use. Flush together with `lu` gives flush only.
- **Timeout counter:** resets on MEM_WAIT entry. It increments each MEM_WAIT cycle.
  - When it reaches `TIMEOUT` (if nonzero), `Mem_Err_o` is set and stays set until reset.
  - The FSM keeps waiting; it does not abort.
- **Stall counter:** `Stall_Cycles_o` increments by 1 in every cycle where `Data_Stall_o` | `Bubble_o`. It saturates at all-ones.
- **Reset (`rst_i`=0 at an edge):**
  - Registered state: state=RUN, `flush_pend`=0, timeout counter=0, `Mem_Err_o`=0, `Stall_Cycles_o`=0.
  - While `rst_i`=0, outputs are forced: `Flush_o`=1, `Bubble_o`=1, `PC_Write_o`=1, `IFID_Write_o`=1, `Data_Stall_o`=0, so the downstream registers load NOPs.
  - A reset asserted during MEM_WAIT abandons the wait immediately.

## Timing
- `PC_Write_o`, `IFID_Write_o`, `Data_Stall_o`, `Bubble_o` and `Flush_o` are combinational from the current state, `flush_pend` and the inputs, so they are valid in the same cycle as the causing inputs.
- The registered outputs, `Mem_Err_o` and `Stall_Cycles_o`, update on the edge following the event.
- **Memory stall length:** for an access acked N cycles after the request cycle, `Data_Stall_o` is high for exactly N cycles. Ack in the request cycle (N=0) gives zero stall and no MEM_WAIT entry.
- **Back-to-back accesses:** a new `Mem_Req_i` in the cycle after the ack cycle (state back in RUN) is handled as a fresh request.
- **Load-use cost:** exactly 1 bubble cycle.
- **Flush:** takes effect in the same cycle as `Branch_Taken_i`, or on the first unstalled cycle if deferred.

## Structure
- `Define.v` gains:
  - `REG_ADDR_LEN` (5)
  - state encodings `ST_RUN` and `ST_MEM_WAIT`
  - the default for `STALL_CNT_LEN`
- Sub-module `load_use_detect` is purely combinational and produces `lu` from the IF/ID and ID/EX fields. It is instantiated once.
- The FSM, `flush_pend`, the timeout counter and the stall counter live in `stall_controller`.

## Test plan
- **Load-use:** `IDEX_MemRead_i`=1, Rd=5, Rs2=5, `UseRs2`=1 → one cycle of `Bubble_o`=1 with `PC_Write_o`=`IFID_Write_o`=0. `Stall_Cycles_o` goes 0→1.
- **x0 filter:** the same stimulus with Rd=0, Rs1=0 → no bubble, enables stay 1.
- **Memory wait:** `Mem_Req_i` with `Mem_Ack_i` arriving 3 cycles later → `Data_Stall_o` high for exactly 3 cycles. The state is MEM_WAIT for those cycles, then RUN. `Stall_Cycles_o`=3.
- **Deferred flush:** `Branch_Taken_i` pulsed during the second MEM_WAIT cycle → `Flush_o`=0 while stalled, then `Flush_o`=1 for one cycle right after the ack.
- **Flush vs load-use:** flush and `lu` in the same cycle → `Flush_o`=1, `Bubble_o`=0, `PC_Write_o`=1.
- **Timeout and reset:** `TIMEOUT`=4 with no ack → `Mem_Err_o`=1 after 4 MEM_WAIT cycles and held. Then `rst_i`=0 for one edge → state RUN, `Mem_Err_o`=0, `Stall_Cycles_o`=0, and `Flush_o`=`Bubble_o`=1 while reset is low.

Source files
------------

// File: rtl/stall_controller_pkg.sv
// Shared widths, FSM encoding and helpers for the pipeline stall/flush
// controller and its hazard detector.
package stall_controller_pkg;

   localparam int REG_ADDR_LEN  = 5;
   localparam int STALL_CNT_LEN = 32;
   localparam int TIMEOUT_DEF   = 255;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

   function automatic logic src_hit(
      input logic      use_src,
      input reg_addr_t rs,
      input reg_addr_t rd
   );
      return use_src && (rs == rd);
   endfunction

endpackage

// File: rtl/stall_controller_load_use_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
// x0 is never a real dependency, so a load targeting it is ignored.
module load_use_detect
   import stall_controller_pkg::*;
(
   input  logic                    IDEX_MemRead_i,
   input  logic [REG_ADDR_LEN-1:0] IDEX_Rd_i,
   input  logic [REG_ADDR_LEN-1:0] IFID_Rs1_i,
   input  logic [REG_ADDR_LEN-1:0] IFID_Rs2_i,
   input  logic                    IFID_UseRs1_i,
   input  logic                    IFID_UseRs2_i,
   output logic                    Lu_o
);

   logic rd_live;
   logic hit1;
   logic hit2;

   assign rd_live = IDEX_MemRead_i && (IDEX_Rd_i != '0);
   assign hit1    = src_hit(IFID_UseRs1_i, IFID_Rs1_i, IDEX_Rd_i);
   assign hit2    = src_hit(IFID_UseRs2_i, IFID_Rs2_i, IDEX_Rd_i);
   assign Lu_o    = rd_live && (hit1 || hit2);

endmodule

// File: rtl/stall_controller.sv
// Stall/flush controller: memory-wait freeze, load-use bubbles, branch
// flushes (deferred across stalls), timeout flag and stall-cycle counter.
module stall_controller
   import stall_controller_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = STALL_CNT_LEN
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    IDEX_MemRead_i,
   input  logic [REG_ADDR_LEN-1:0] IDEX_Rd_i,
   input  logic [REG_ADDR_LEN-1:0] IFID_Rs1_i,
   input  logic [REG_ADDR_LEN-1:0] IFID_Rs2_i,
   input  logic                    IFID_UseRs1_i,
   input  logic                    IFID_UseRs2_i,
   input  logic                    Mem_Req_i,
   input  logic                    Mem_Ack_i,
   input  logic                    Branch_Taken_i,
   output logic                    PC_Write_o,
   output logic                    IFID_Write_o,
   output logic                    Data_Stall_o,
   output logic                    Bubble_o,
   output logic                    Flush_o,
   output logic                    Mem_Err_o,
   output logic [CNT_W-1:0]        Stall_Cycles_o
);

   localparam int            TW   = $clog2(TIMEOUT + 2);
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

   state_e           state_q;
   logic             flush_pend_q;
   logic             err_q;
   logic [TW-1:0]    tcnt_q;
   logic [TW-1:0]    tcnt_inc;
   logic [CNT_W-1:0] cnt_q;

   logic lu;
   logic mem_stall;
   logic flush_go;
   logic bubble;

   load_use_detect u_lu (
      .IDEX_MemRead_i (IDEX_MemRead_i),
      .IDEX_Rd_i      (IDEX_Rd_i),
      .IFID_Rs1_i     (IFID_Rs1_i),
      .IFID_Rs2_i     (IFID_Rs2_i),
      .IFID_UseRs1_i  (IFID_UseRs1_i),
      .IFID_UseRs2_i  (IFID_UseRs2_i),
      .Lu_o           (lu)
   );

   // Memory stall wins over flush, flush wins over load-use.
   assign mem_stall = (state_q == ST_RUN) ? (Mem_Req_i & ~Mem_Ack_i)
                                          : ~Mem_Ack_i;
   assign flush_go  = ~mem_stall & (Branch_Taken_i | flush_pend_q);
   assign bubble    = ~mem_stall & ~flush_go & lu;
   assign tcnt_inc  = tcnt_q + 1'b1;

   always_comb begin
      PC_Write_o   = 1'b1;
      IFID_Write_o = 1'b1;
      Data_Stall_o = 1'b0;
      Bubble_o     = 1'b0;
      Flush_o      = 1'b0;
      priority case (1'b1)
         !rst_i: begin
            Bubble_o = 1'b1;
            Flush_o  = 1'b1;
         end
         mem_stall: begin
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            Data_Stall_o = 1'b1;
         end
         flush_go: begin
            Flush_o = 1'b1;
         end
         bubble: begin
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            Bubble_o     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= ST_RUN;
         flush_pend_q <= 1'b0;
         tcnt_q       <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (Mem_Req_i && !Mem_Ack_i) begin
                  state_q <= ST_MEM_WAIT;
                  tcnt_q  <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (tcnt_q != TLIM) tcnt_q <= tcnt_inc;
               if (TIMEOUT != 0 && tcnt_inc == TLIM) err_q <= 1'b1;
               if (Mem_Ack_i) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase

         if (mem_stall && Branch_Taken_i) flush_pend_q <= 1'b1;
         else if (!mem_stall)             flush_pend_q <= 1'b0;

         if ((mem_stall || bubble) && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign Mem_Err_o      = err_q;
   assign Stall_Cycles_o = cnt_q;

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller: every cycle is checked against a
// rule-level model, with literal expectations pinning key scenarios.
module tb_stall_controller;

   localparam int TO   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ld = 1'b0;
   logic [4:0] rd = '0;
   logic [4:0] rs1 = '0;
   logic [4:0] rs2 = '0;
   logic       u1 = 1'b0;
   logic       u2 = 1'b0;
   logic       req = 1'b0;
   logic       ack = 1'b0;
   logic       br = 1'b0;

   logic          pc_w;
   logic          ifid_w;
   logic          ds;
   logic          bub;
   logic          fl;
   logic          merr;
   logic [CW-1:0] scnt;

   int errors = 0;
   int checks = 0;

   bit m_wait = 0;
   bit m_pend = 0;
   bit m_err  = 0;
   int m_wc   = 0;
   int m_cnt  = 0;

   logic          s_pc, s_if, s_ds, s_bub, s_fl, s_err;
   logic [CW-1:0] s_cnt;

   stall_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .IDEX_MemRead_i (ld),
      .IDEX_Rd_i      (rd),
      .IFID_Rs1_i     (rs1),
      .IFID_Rs2_i     (rs2),
      .IFID_UseRs1_i  (u1),
      .IFID_UseRs2_i  (u2),
      .Mem_Req_i      (req),
      .Mem_Ack_i      (ack),
      .Branch_Taken_i (br),
      .PC_Write_o     (pc_w),
      .IFID_Write_o   (ifid_w),
      .Data_Stall_o   (ds),
      .Bubble_o       (bub),
      .Flush_o        (fl),
      .Mem_Err_o      (merr),
      .Stall_Cycles_o (scnt)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic drive(input bit l, input int d, input int a, input int b,
                        input bit x1, input bit x2, input bit rq,
                        input bit ak, input bit bt);
      ld = l; rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b);
      u1 = x1; u2 = x2; req = rq; ack = ak; br = bt;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // One clock: compare outputs mid-cycle, then advance the model.
   task automatic step();
      bit stall, f, lu, bb, en;
      @(negedge clk);
      lu = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!rst) begin
         stall = 0; f = 1; bb = 1; en = 1;
      end else begin
         stall = m_wait ? !ack : (req && !ack);
         f     = !stall && (br || m_pend);
         bb    = !stall && !f && lu;
         en    = !stall && !bb;
      end
      s_pc = pc_w; s_if = ifid_w; s_ds = ds; s_bub = bub;
      s_fl = fl; s_err = merr; s_cnt = scnt;
      chk("pc_write", 32'(s_pc), 32'(en));
      chk("ifid_write", 32'(s_if), 32'(en));
      chk("data_stall", 32'(s_ds), 32'(stall));
      chk("bubble", 32'(s_bub), 32'(bb));
      chk("flush", 32'(s_fl), 32'(f));
      chk("mem_err", 32'(s_err), 32'(m_err));
      chk("stall_cycles", 32'(s_cnt), 32'(m_cnt));
      @(posedge clk);
      if (!rst) begin
         m_wait = 0; m_pend = 0; m_err = 0; m_wc = 0; m_cnt = 0;
      end else begin
         if (!m_wait) begin
            if (req && !ack) begin
               m_wait = 1;
               m_wc   = 0;
            end
         end else begin
            m_wc++;
            if (TO != 0 && m_wc == TO) m_err = 1;
            if (ack) m_wait = 0;
         end
         if (stall && br) m_pend = 1;
         else if (!stall) m_pend = 0;
         if ((stall || bb) && m_cnt < CMAX) m_cnt++;
      end
      #1;
   endtask

   initial begin
      int nds;
      logic [4:0] dfl;

      idle();
      rst = 0;
      step();
      chk("rst_flush", 32'(s_fl), 1);
      chk("rst_bubble", 32'(s_bub), 1);
      step();
      rst = 1;
      step();
      chk("cnt_zero", 32'(s_cnt), 0);
      chk("err_zero", 32'(s_err), 0);

      drive(1, 5, 0, 5, 0, 1, 0, 0, 0);
      step();
      chk("lu_bubble", 32'(s_bub), 1);
      chk("lu_pc", 32'(s_pc), 0);
      idle();
      step();
      chk("lu_cnt", 32'(s_cnt), 1);
      chk("lu_lapsed", 32'(s_bub), 0);

      drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
      step();
      chk("x0_bubble", 32'(s_bub), 0);
      chk("x0_pc", 32'(s_pc), 1);

      idle();
      rst = 0;
      step();
      rst = 1;

      nds = 0;
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 0, 0, 1, k == 3, 0);
         step();
         nds += int'(s_ds);
      end
      idle();
      step();
      chk("mem_stall_len", 32'(nds), 3);
      chk("mem_cnt", 32'(s_cnt), 3);

      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 0, 0, 0, k <= 3, k == 3, k == 2);
         step();
         dfl[k] = s_fl;
      end
      chk("dfl_stalled", 32'(dfl[2:0]), 0);
      chk("dfl_applied", 32'(dfl[3]), 1);
      chk("dfl_cleared", 32'(dfl[4]), 0);

      drive(1, 7, 7, 0, 1, 0, 0, 0, 1);
      step();
      chk("fvl_flush", 32'(s_fl), 1);
      chk("fvl_bubble", 32'(s_bub), 0);
      chk("fvl_pc", 32'(s_pc), 1);

      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 0, 0, 0, k < 4, k == 1 || k == 3, 0);
         step();
         if (k == 2) chk("b2b_fresh", 32'(s_ds), 1);
      end

      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step();
      chk("zero_wait", 32'(s_ds), 0);

      for (int k = 0; k < 20; k++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
         step();
         if (k == 4) chk("err_pre", 32'(s_err), 0);
         if (k == 5) chk("err_set", 32'(s_err), 1);
      end
      chk("err_held", 32'(s_err), 1);
      chk("cnt_sat", 32'(s_cnt), CMAX);

      idle();
      rst = 0;
      step();
      chk("rstw_flush", 32'(s_fl), 1);
      chk("rstw_bubble", 32'(s_bub), 1);
      chk("rstw_stall", 32'(s_ds), 0);
      rst = 1;
      step();
      chk("post_err", 32'(s_err), 0);
      chk("post_cnt", 32'(s_cnt), 0);
      chk("post_run", 32'(s_ds), 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
